alu_dispatcher: RTL and testbench
=================================

ALU_DISPATCHER -- requirements
Module: alu_dispatcher

Parameters
REQ-001 DATA_W, default 8, operand/result width in bits.
REQ-002 N_UNITS, default 8, number of functional-unit channels; opcode width OPC_W = clog2(N_UNITS).
REQ-003 UNIT_MASK, default 8'b1011_1111, bit i = 1 means channel i implemented (channel 6 unused by default).
REQ-004 TIMEOUT, default 16, max cycles spent waiting for a unit's done (range 1..255).

Interface
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 start  in  1  request a new operation; sampled only in IDLE.
REQ-008 opcode  in  OPC_W  channel select, sampled with start.
REQ-009 data_in  in  DATA_W  operand bus, sampled in READ.
REQ-010 rd  out  1  operand read strobe.
REQ-011 wr  out  1  result write strobe.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 unit_start  out  N_UNITS  one-hot, one-cycle start to the selected unit.
REQ-014 unit_data  out  DATA_W  latched operand broadcast to all units.
REQ-015 unit_done  in  N_UNITS  per-unit completion, one bit per channel.
REQ-016 unit_result  in  N_UNITS*DATA_W  per-unit result; channel i = bits [i*DATA_W +: DATA_W].
REQ-017 data_out  out  DATA_W  registered result of the last successful operation.
REQ-018 done  out  1  one-cycle pulse on successful completion.
REQ-019 err  out  1  one-cycle pulse on unmapped opcode or timeout.
REQ-020 err_code  out  2  cause of the last error: 01 unmapped, 10 timeout, 00 none; held until next error or reset.

Function
REQ-021 FSM states: IDLE, READ, DISPATCH, WAIT, WRITE, ERR; outputs rd/wr/unit_start/done/err decoded from registered state only.
REQ-022 IDLE: start=1 latches opcode into opc_q; next state READ if UNIT_MASK[opcode]=1, otherwise ERR with err_code <= 01.
REQ-023 start while busy=1 is ignored (not queued).
REQ-024 READ: rd=1 for exactly one cycle; data_in captured into operand register at end of the cycle; next DISPATCH.
REQ-025 DISPATCH: unit_start[opc_q]=1 for exactly one cycle, all other bits 0; next WAIT.
REQ-026 unit_data = operand register at all times; stable from DISPATCH through WRITE.
REQ-027 WAIT: wait counter cleared on entry, +1 per WAIT cycle; unit_done[opc_q]=1 captures unit_result slice opc_q into data_out, next WRITE.
REQ-028 unit_done bits of non-selected channels are ignored in every state.
REQ-029 WAIT timeout: no selected done by the TIMEOUT-th WAIT cycle -> ERR, err_code <= 10; done and timeout in the same cycle -> done wins.
REQ-030 WRITE: wr=1 and done=1 for exactly one cycle; next IDLE.
REQ-031 ERR: err=1 for exactly one cycle, data_out unchanged, no wr; next IDLE.
REQ-032 Latency: start in cycle 0, selected done in cycle 3 -> wr/done in cycle 4 (5-cycle minimum operation); back-to-back start accepted in cycle 5.
REQ-033 rd and wr never asserted in the same cycle; at most one unit_start bit high in any cycle.

Reset
REQ-034 rst_n=0 at a rising edge forces IDLE regardless of current state, including mid-WAIT.
REQ-035 Reset values: rd=0, wr=0, busy=0, unit_start=0, done=0, err=0, err_code=00, data_out=0, operand=0, opc_q=0, wait counter=0.
REQ-036 A unit_done arriving in the cycle after a reset abort is ignored.

Verification
REQ-037 opcode=0, data_in=8'h3C, unit_result[7:0]=8'h5A with unit_done[0] in cycle 3 -> rd cycle 1, unit_start=8'h01 cycle 2, data_out=8'h5A, wr/done cycle 4.
REQ-038 start with opcode=6 (masked) -> err pulse cycle 1, err_code=01, no rd, no unit_start, data_out unchanged.
REQ-039 opcode=3, unit_done never asserted, TIMEOUT=16 -> err pulse exactly 16 WAIT cycles after DISPATCH, err_code=10, no wr.
REQ-040 opcode=5 in WAIT, unit_done[2] pulsed then unit_done[5] -> only unit_done[5] completes; data_out = slice 5.
REQ-041 rst_n=0 during WAIT of opcode=1 -> next cycle IDLE, all outputs at reset values; later unit_done[1] produces no done.
REQ-042 start held high continuously with opcode=7 -> ops complete every 6 cycles, one done per op, start during busy ignored.

Source files
------------

// File: rtl/alu_dispatcher.sv
// alu_dispatcher: reads one operand, starts the selected functional unit, waits
// (bounded by TIMEOUT) for that unit's done, then writes back its result.
module alu_dispatcher #(
    parameter int                 DATA_W    = 8,
    parameter int                 N_UNITS   = 8,
    parameter logic [N_UNITS-1:0] UNIT_MASK = 8'b1011_1111,
    parameter int                 TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(N_UNITS)-1:0]  opcode,
    input  logic [DATA_W-1:0]           data_in,
    output logic                        rd,
    output logic                        wr,
    output logic                        busy,
    output logic [N_UNITS-1:0]          unit_start,
    output logic [DATA_W-1:0]           unit_data,
    input  logic [N_UNITS-1:0]          unit_done,
    input  logic [N_UNITS*DATA_W-1:0]   unit_result,
    output logic [DATA_W-1:0]           data_out,
    output logic                        done,
    output logic                        err,
    output logic [1:0]                  err_code,
    output logic [2:0]                  state_o
);

    localparam int OPC_W = $clog2(N_UNITS);
    localparam int N_SEL = 1 << OPC_W;
    // Opcodes beyond N_UNITS (non power-of-two unit counts) read as unmapped.
    localparam logic [N_SEL-1:0] MASK_EXT = N_SEL'(UNIT_MASK);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_DISPATCH = 3'd2,
        S_WAIT     = 3'd3,
        S_WRITE    = 3'd4,
        S_ERR      = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [DATA_W-1:0]   operand_q, operand_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [1:0]          err_code_q, err_code_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            opc_q      <= '0;
            operand_q  <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            operand_q  <= operand_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
        end
    end

    // start is a one-shot request honoured only while busy is low; a request
    // made while busy is dropped, never queued.
    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        operand_d  = operand_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opc_d = opcode;
                    if (MASK_EXT[opcode]) begin
                        state_d = S_READ;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = 2'b01;
                    end
                end
            end
            S_READ: begin
                operand_d = data_in;
                state_d   = S_DISPATCH;
            end
            S_DISPATCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A done arriving on the last allowed cycle still wins over the timeout.
                if (unit_done[opc_q]) begin
                    result_d = unit_result[int'(opc_q)*DATA_W +: DATA_W];
                    state_d  = S_WRITE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b10;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd         = (state_q == S_READ);
    assign wr         = (state_q == S_WRITE);
    assign done       = (state_q == S_WRITE);
    assign err        = (state_q == S_ERR);
    assign busy       = (state_q != S_IDLE);
    assign unit_start = (state_q == S_DISPATCH) ? (N_UNITS'(1) << opc_q) : '0;
    assign unit_data  = operand_q;
    assign data_out   = result_q;
    assign err_code   = err_code_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_alu_dispatcher.sv
// Bench for alu_dispatcher: directed segments followed by random traffic, all
// compared cycle by cycle against an operation-timeline model built up front.
module tb_alu_dispatcher;

    localparam int          N_CYC   = 2000;
    localparam int          TIMEOUT = 16;
    localparam logic [7:0]  MASK    = 8'b1011_1111;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  opcode;
    logic [7:0]  data_in;
    logic        rd, wr, busy, done, err;
    logic [7:0]  unit_start, unit_data, data_out;
    logic [7:0]  unit_done;
    logic [63:0] unit_result;
    logic [1:0]  err_code;
    logic [2:0]  state_dbg;

    alu_dispatcher #(
        .DATA_W(8), .N_UNITS(8), .UNIT_MASK(MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .data_in(data_in), .rd(rd), .wr(wr), .busy(busy),
        .unit_start(unit_start), .unit_data(unit_data),
        .unit_done(unit_done), .unit_result(unit_result),
        .data_out(data_out), .done(done), .err(err),
        .err_code(err_code), .state_o(state_dbg)
    );

    // Stimulus schedule, one entry per cycle.
    bit          rst_s[N_CYC];
    bit          start_s[N_CYC];
    logic [2:0]  op_s[N_CYC];
    logic [7:0]  din_s[N_CYC];
    logic [7:0]  ud_s[N_CYC];
    logic [63:0] res_s[N_CYC];

    // Expected outputs per cycle.
    bit          e_rd[N_CYC], e_wr[N_CYC], e_err[N_CYC], e_busy[N_CYC];
    logic [7:0]  e_us[N_CYC], e_ud[N_CYC], e_dout[N_CYC];
    logic [1:0]  e_ec[N_CYC];

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    task automatic put(input int c, input bit r, input bit w, input bit e, input bit b,
                       input logic [7:0] us, input logic [7:0] ud, input logic [7:0] dout,
                       input logic [1:0] ec);
        e_rd[c] = r; e_wr[c] = w; e_err[c] = e; e_busy[c] = b;
        e_us[c] = us; e_ud[c] = ud; e_dout[c] = dout; e_ec[c] = ec;
    endtask

    task automatic gen_stimulus();
        for (int c = 0; c < N_CYC; c++) begin
            rst_s[c] = 1'b1; start_s[c] = 1'b0; op_s[c] = 3'd0;
            din_s[c] = 8'h00; ud_s[c] = 8'h00; res_s[c] = 64'h0;
        end
        rst_s[0] = 1'b0;
        // Basic op on channel 0.
        start_s[4] = 1'b1; op_s[4] = 3'd0; din_s[5] = 8'h3C;
        ud_s[7] = 8'h01; res_s[7] = 64'hFFFF_FFFF_FFFF_FF5A;
        // Unmapped channel 6.
        start_s[14] = 1'b1; op_s[14] = 3'd6;
        // Channel 3 never answers.
        start_s[20] = 1'b1; op_s[20] = 3'd3; din_s[21] = 8'h77;
        // Channel 5 with a stray done on channel 2 first.
        start_s[44] = 1'b1; op_s[44] = 3'd5; din_s[45] = 8'h12;
        ud_s[47] = 8'h04; res_s[47] = 64'h1111_1111_1111_1111;
        ud_s[49] = 8'h20; res_s[49] = 64'h0000_A5EE_EEEE_EEEE;
        // Reset abort during WAIT of channel 1, late done afterwards.
        start_s[55] = 1'b1; op_s[55] = 3'd1; din_s[56] = 8'h99;
        rst_s[60] = 1'b0;
        ud_s[61] = 8'h02; ud_s[62] = 8'h02; res_s[61] = 64'hFF; res_s[62] = 64'hFF00;
        // start held high on channel 7, unit answers on its second WAIT cycle.
        for (int c = 70; c <= 105; c++) begin
            start_s[c] = 1'b1; op_s[c] = 3'd7; din_s[c] = 8'(c);
            res_s[c] = {8'(c), 56'h0};
            if ((c - 70) % 6 == 4) ud_s[c] = 8'h80;
        end
        // Random traffic.
        for (int c = 110; c < N_CYC; c++) begin
            rst_s[c]   = ($urandom_range(0, 149) != 0);
            start_s[c] = ($urandom_range(0, 2) == 0);
            op_s[c]    = 3'($urandom_range(0, 7));
            din_s[c]   = 8'($urandom);
            for (int b = 0; b < 8; b++) ud_s[c][b] = ($urandom_range(0, 7) == 0);
            res_s[c]   = {$urandom, $urandom};
        end
    endtask

    // Walks the schedule one operation at a time: an accepted op occupies a
    // fixed run of cycles (read, dispatch, wait window, write/err), truncated
    // by any reset inside it.
    task automatic build_model();
        logic [7:0] dout, operand, us;
        logic [1:0] ec;
        logic [2:0] opc;
        int t, x, last, k;
        bit mapped, found, aborted;
        dout = 8'h00; operand = 8'h00; ec = 2'b00; t = 1;
        while (t < N_CYC) begin
            put(t, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, operand, dout, ec);
            if (!rst_s[t]) begin
                dout = 8'h00; operand = 8'h00; ec = 2'b00; t++;
            end else if (!start_s[t]) begin
                t++;
            end else begin
                opc = op_s[t]; mapped = MASK[opc]; found = 1'b0; k = 0;
                if (!mapped) begin
                    ec = 2'b01; last = t + 1;
                end else begin
                    last = t + 3 + TIMEOUT;
                    for (int w = t + 3; w <= t + 2 + TIMEOUT && !found; w++) begin
                        if (w < N_CYC && ud_s[w][opc]) begin
                            found = 1'b1; k = w; last = w + 1;
                        end
                    end
                end
                x = t + 1; aborted = 1'b0;
                while (x <= last && x < N_CYC && !aborted) begin
                    us = (mapped && x == t + 2) ? (8'h01 << opc) : 8'h00;
                    put(x, mapped && x == t + 1, found && x == last, !found && x == last,
                        1'b1, us, operand, dout, ec);
                    if (!rst_s[x]) begin
                        dout = 8'h00; operand = 8'h00; ec = 2'b00; aborted = 1'b1;
                    end else begin
                        if (mapped && x == t + 1) operand = din_s[x];
                        if (found && x == k) dout = res_s[x][opc*8 +: 8];
                        if (mapped && !found && x == last - 1) ec = 2'b10;
                    end
                    x++;
                end
                t = x;
            end
        end
    endtask

    task automatic pin_model();
        int nwr;
        chk("lit_a_rd", 5, 64'(e_rd[5]), 64'd1);
        chk("lit_a_ustart", 6, 64'(e_us[6]), 64'h01);
        chk("lit_a_udata", 6, 64'(e_ud[6]), 64'h3C);
        chk("lit_a_wr", 8, 64'(e_wr[8]), 64'd1);
        chk("lit_a_dout", 8, 64'(e_dout[8]), 64'h5A);
        chk("lit_a_idle", 9, 64'(e_busy[9]), 64'd0);
        chk("lit_b_err", 15, 64'(e_err[15]), 64'd1);
        chk("lit_b_ec", 15, 64'(e_ec[15]), 64'd1);
        chk("lit_b_rd", 15, 64'(e_rd[15]), 64'd0);
        chk("lit_b_dout", 15, 64'(e_dout[15]), 64'h5A);
        chk("lit_c_noerr", 38, 64'(e_err[38]), 64'd0);
        chk("lit_c_err", 39, 64'(e_err[39]), 64'd1);
        chk("lit_c_ec", 39, 64'(e_ec[39]), 64'd2);
        chk("lit_c_idle", 40, 64'(e_busy[40]), 64'd0);
        chk("lit_d_nowr", 48, 64'(e_wr[48]), 64'd0);
        chk("lit_d_wr", 50, 64'(e_wr[50]), 64'd1);
        chk("lit_d_dout", 50, 64'(e_dout[50]), 64'hA5);
        chk("lit_e_busy", 60, 64'(e_busy[60]), 64'd1);
        chk("lit_e_idle", 61, 64'(e_busy[61]), 64'd0);
        chk("lit_e_dout", 61, 64'(e_dout[61]), 64'h00);
        chk("lit_e_ec", 61, 64'(e_ec[61]), 64'd0);
        chk("lit_e_nowr", 62, 64'(e_wr[62] | e_wr[63]), 64'd0);
        chk("lit_f_wr", 75, 64'(e_wr[75]), 64'd1);
        chk("lit_f_dout", 75, 64'(e_dout[75]), 64'd74);
        chk("lit_f_nowr", 80, 64'(e_wr[80]), 64'd0);
        nwr = 0;
        for (int c = 70; c <= 105; c++) nwr += int'(e_wr[c]);
        chk("lit_f_count", 105, 64'(nwr), 64'd6);
    endtask

    task automatic drive(input int c);
        rst_n       = rst_s[c];
        start       = start_s[c];
        opcode      = op_s[c];
        data_in     = din_s[c];
        unit_done   = ud_s[c];
        unit_result = res_s[c];
    endtask

    initial begin
        gen_stimulus();
        build_model();
        pin_model();
        drive(0);
        for (int c = 0; c < N_CYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            drive(c);
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("rd", cyc, 64'(rd), 64'(e_rd[cyc]));
            chk("wr", cyc, 64'(wr), 64'(e_wr[cyc]));
            chk("done", cyc, 64'(done), 64'(e_wr[cyc]));
            chk("err", cyc, 64'(err), 64'(e_err[cyc]));
            chk("busy", cyc, 64'(busy), 64'(e_busy[cyc]));
            chk("unit_start", cyc, 64'(unit_start), 64'(e_us[cyc]));
            chk("unit_data", cyc, 64'(unit_data), 64'(e_ud[cyc]));
            chk("data_out", cyc, 64'(data_out), 64'(e_dout[cyc]));
            chk("err_code", cyc, 64'(err_code), 64'(e_ec[cyc]));
            chk("state_idle", cyc, 64'(state_dbg == 3'd0), 64'(!e_busy[cyc]));
        end
    end

endmodule
